// File: rtl/jtag_shift_engine_if.sv
// Command/response handshake bundle for jtag_shift_engine.
//   master : command source / response sink (drives div, cmd_*, rsp_ready)
//   slave  : the shift engine (drives cmd_ready, rsp_valid, rsp_tdo)
// Signals:
//   div         TCK half-period minus 1, in clk cycles
//   cmd_valid   command offered        cmd_ready   engine idle and accepting
//   cmd_len     bit count minus 1      cmd_tdi/tms bits to shift, LSB first
//   cmd_capture return captured TDO    rsp_valid   captured data available
//   rsp_ready   consumer ready         rsp_tdo     captured TDO bits
interface jtag_shift_engine_if #(
    parameter int DIV_WIDTH = 8
);
    logic [DIV_WIDTH-1:0] div;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_len;
    logic [7:0]           cmd_tdi;
    logic [7:0]           cmd_tms;
    logic                 cmd_capture;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_tdo;

    modport master (
        output div, cmd_valid, cmd_len, cmd_tdi, cmd_tms, cmd_capture, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo
    );

    modport slave (
        input  div, cmd_valid, cmd_len, cmd_tdi, cmd_tms, cmd_capture, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo
    );
endinterface

// File: rtl/jtag_shift_engine.sv
// Byte-oriented JTAG shift engine. Accepts a command of 1..8 TDI/TMS bits,
// produces a TCK waveform with a programmable half period, samples TDO on
// each TCK fall and optionally returns the captured bits.
// Ports:
//   clk   system clock, all state changes on its rising edge
//   rst   asynchronous reset, active high
//   bus   command/response handshake (slave side)
//   tck   JTAG clock toward the buffer stage
//   tdi   JTAG data toward the buffer stage
//   tms   JTAG mode select toward the buffer stage
//   tdo   JTAG data returning from the buffer stage
//   busy  high whenever the engine is not idle
module jtag_shift_engine #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    jtag_shift_engine_if.slave    bus,
    output logic                  tck,
    output logic                  tdi,
    output logic                  tms,
    input  logic                  tdo,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state_reg;
    state_t               state_next;

    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [2:0]           len_reg;
    logic [2:0]           idx_reg;
    logic [7:0]           tdi_bits_reg;
    logic [7:0]           tms_bits_reg;
    logic                 capture_en_reg;
    logic [7:0]           cap_reg;
    logic [7:0]           cap_next;
    logic [7:0]           rsp_tdo_reg;
    logic                 tdi_reg;
    logic                 tms_reg;

    logic                 cnt_zero;
    logic                 last_bit;
    logic [2:0]           idx_inc;

    assign cnt_zero = (cnt_reg == '0);
    assign last_bit = (idx_reg == len_reg);
    assign idx_inc  = idx_reg + 3'd1;

    // Capture register with the current TDO merged into the active bit slot;
    // this is what gets stored on the TCK falling edge.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cap
            assign cap_next[gi] = (idx_reg == 3'(gi)) ? tdo : cap_reg[gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.cmd_valid) state_next = LOW;
            LOW:  if (cnt_zero) state_next = HIGH;
            HIGH: begin
                if (cnt_zero) begin
                    if (!last_bit)           state_next = LOW;
                    else if (capture_en_reg) state_next = RESP;
                    else                     state_next = IDLE;
                end
            end
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: command latches, half-period counter, bit index, shifters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg        <= '0;
            cnt_reg        <= '0;
            len_reg        <= '0;
            idx_reg        <= '0;
            tdi_bits_reg   <= '0;
            tms_bits_reg   <= '0;
            capture_en_reg <= 1'b0;
            cap_reg        <= '0;
            rsp_tdo_reg    <= '0;
            tdi_reg        <= 1'b0;
            tms_reg        <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        div_reg        <= bus.div;
                        len_reg        <= bus.cmd_len;
                        tdi_bits_reg   <= bus.cmd_tdi;
                        tms_bits_reg   <= bus.cmd_tms;
                        capture_en_reg <= bus.cmd_capture;
                        tdi_reg        <= bus.cmd_tdi[0];
                        tms_reg        <= bus.cmd_tms[0];
                        idx_reg        <= '0;
                        cap_reg        <= '0;
                        cnt_reg        <= bus.div;
                    end
                end
                LOW: begin
                    cnt_reg <= cnt_zero ? div_reg : cnt_reg - 1'b1;
                end
                HIGH: begin
                    if (cnt_zero) begin
                        // TCK falls here: TDO is sampled late in the high
                        // phase, and the next TDI/TMS bit launches together
                        // with the fall.
                        cap_reg <= cap_next;
                        if (!last_bit) begin
                            idx_reg <= idx_inc;
                            tdi_reg <= tdi_bits_reg[idx_inc];
                            tms_reg <= tms_bits_reg[idx_inc];
                            cnt_reg <= div_reg;
                        end else if (capture_en_reg) begin
                            rsp_tdo_reg <= cap_next;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches TCK/TDI/TMS
    // combinationally, and reset forces them immediately.
    always_comb begin
        tck           = (state_reg == HIGH);
        busy          = (state_reg != IDLE);
        bus.cmd_ready = (state_reg == IDLE);
        bus.rsp_valid = (state_reg == RESP);
        bus.rsp_tdo   = rsp_tdo_reg;
        tdi           = tdi_reg;
        tms           = tms_reg;
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
module tb_jtag_shift_engine;

    logic clk;
    logic rst;
    logic tck, tdi, tms, busy;
    logic tdo;
    logic tdo_loop;
    logic tdo_drv;
    logic [7:0] tdo_pat;

    int vectors;
    int miscompares;
    int cyc;

    int   rise_cyc[$];
    logic rise_tdi[$];
    logic rise_tms[$];
    logic tck_prev;

    jtag_shift_engine_if #(.DIV_WIDTH(8)) bus_if ();

    jtag_shift_engine #(.DIV_WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if.slave),
        .tck  (tck),
        .tdi  (tdi),
        .tms  (tms),
        .tdo  (tdo),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Target model: presents TDO for bit k (from a pattern, or looped back
    // from TDI) during the high phase after the k-th TCK rise.
    assign tdo = tdo_loop ? tdi : tdo_drv;

    initial tck_prev = 1'b0;
    always @(negedge clk) begin
        if (tck === 1'b1 && tck_prev !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_tdi.push_back(tdi);
            rise_tms.push_back(tms);
            tdo_drv = tdo_pat[3'(rise_cyc.size() - 1)];
        end
        tck_prev = tck;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tck"},       32'(tck), 32'd0);
        chk({tag, "_tms"},       32'(tms), 32'd1);
        chk({tag, "_tdi"},       32'(tdi), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_rsp_tdo"},   32'(bus_if.rsp_tdo), 32'd0);
    endtask

    // Issue one command (called at a negedge) and check the complete
    // transaction against the timing rules: first rise at t+DIV+1, rises
    // every 2(DIV+1), completion at t+2N(DIV+1), captured bits masked to N.
    task automatic run_cmd(input int dv, input int ln, input logic [7:0] ti,
                           input logic [7:0] tm, input bit cap, input int hold);
        int n, t, waits;
        logic [7:0] mask, exp_tdo;
        n       = ln + 1;
        mask    = 8'((16'd1 << n) - 16'd1);
        exp_tdo = (tdo_loop ? ti : tdo_pat) & mask;

        bus_if.div         = 8'(dv);
        bus_if.cmd_len     = 3'(ln);
        bus_if.cmd_tdi     = ti;
        bus_if.cmd_tms     = tm;
        bus_if.cmd_capture = cap;
        bus_if.cmd_valid   = 1'b1;
        waits = 0;
        while (bus_if.cmd_ready !== 1'b1 && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        chk("accept_wait", 32'(waits < 300), 32'd1);
        rise_cyc.delete();
        rise_tdi.delete();
        rise_tms.delete();
        @(negedge clk);
        t = cyc;
        bus_if.cmd_valid = 1'b0;
        bus_if.div       = ~8'(dv);   // must not affect the running command
        chk("accept_busy",  32'(busy), 32'd1);
        chk("accept_ready", 32'(bus_if.cmd_ready), 32'd0);
        chk("bit0_tdi",     32'(tdi), 32'(ti[0]));
        chk("bit0_tms",     32'(tms), 32'(tm[0]));

        waits = 0;
        while (bus_if.cmd_ready !== 1'b1 && bus_if.rsp_valid !== 1'b1 && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        chk("done_wait",  32'(waits < 300), 32'd1);
        chk("done_cycle", 32'(cyc - t), 32'(2 * n * (dv + 1)));
        chk("done_tck",   32'(tck), 32'd0);
        chk("rise_count", 32'(rise_cyc.size()), 32'(n));
        for (int k = 0; k < rise_cyc.size() && k < 8; k++) begin
            chk("rise_cycle", 32'(rise_cyc[k] - t), 32'((dv + 1) * (2 * k + 1)));
            chk("rise_tdi",   32'(rise_tdi[k]), 32'(ti[k]));
            chk("rise_tms",   32'(rise_tms[k]), 32'(tm[k]));
        end
        chk("done_rsp_valid", 32'(bus_if.rsp_valid), 32'(cap));
        chk("done_cmd_ready", 32'(bus_if.cmd_ready), 32'(!cap));
        if (cap) begin
            chk("rsp_tdo", 32'(bus_if.rsp_tdo), 32'(exp_tdo));
            bus_if.cmd_valid = 1'b1;   // offered while busy: must not be taken
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
                chk("hold_rsp_tdo",   32'(bus_if.rsp_tdo), 32'(exp_tdo));
                chk("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
                chk("hold_tck",       32'(tck), 32'd0);
            end
            bus_if.cmd_valid = 1'b0;
            bus_if.rsp_ready = 1'b1;
            @(negedge clk);
            bus_if.rsp_ready = 1'b0;
            chk("rsp_release_valid", 32'(bus_if.rsp_valid), 32'd0);
            chk("rsp_release_ready", 32'(bus_if.cmd_ready), 32'd1);
        end
        $display("cmd div=%0d len=%0d tdi=%02h tms=%02h cap=%0d rsp=%02h exp=%02h",
                 dv, ln, ti, tm, cap, bus_if.rsp_tdo, exp_tdo);
    endtask

    initial begin
        int waits, nr;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        tdo_loop    = 1'b0;
        tdo_drv     = 1'b0;
        tdo_pat     = 8'h00;
        bus_if.div         = 8'd0;
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_len     = 3'd0;
        bus_if.cmd_tdi     = 8'h00;
        bus_if.cmd_tms     = 8'h00;
        bus_if.cmd_capture = 1'b0;
        bus_if.rsp_ready   = 1'b0;
        #1;
        check_reset("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Loopback, fastest divider, full byte
        tdo_loop = 1'b1;
        run_cmd(0, 7, 8'hA5, 8'h00, 1'b1, 0);

        // Divider with no capture; TMS must rest at the last shifted value
        tdo_loop = 1'b0;
        tdo_pat  = 8'h00;
        run_cmd(3, 1, 8'b10, 8'b11, 1'b0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_tms",       32'(tms), 32'd1);
            chk("idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        end

        // Response backpressure
        tdo_pat = 8'hFF;
        run_cmd(1, 2, 8'h3C, 8'h05, 1'b1, 10);

        // Single bit
        tdo_pat = 8'h01;
        run_cmd(0, 0, 8'h00, 8'h00, 1'b1, 0);

        // Randomized commands, back to back
        for (int r = 0; r < 16; r++) begin
            tdo_loop = 1'($urandom_range(0, 1));
            tdo_pat  = 8'($urandom);
            run_cmd($urandom_range(0, 3), $urandom_range(0, 7), 8'($urandom),
                    8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Abort during the 5th bit of an 8-bit command
        tdo_loop = 1'b1;
        bus_if.div         = 8'd1;
        bus_if.cmd_len     = 3'd7;
        bus_if.cmd_tdi     = 8'hC3;
        bus_if.cmd_tms     = 8'h00;
        bus_if.cmd_capture = 1'b1;
        bus_if.cmd_valid   = 1'b1;
        waits = 0;
        while (bus_if.cmd_ready !== 1'b1 && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        rise_cyc.delete();
        rise_tdi.delete();
        rise_tms.delete();
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        waits = 0;
        while (rise_cyc.size() < 5 && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        chk("abort_reach_bit5", 32'(waits < 300), 32'd1);
        chk("abort_tck_high",   32'(tck), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("abort");
        nr = rise_cyc.size();
        repeat (3) @(negedge clk);
        check_reset("abort_hold");
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_abort_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
            chk("post_abort_tck",       32'(tck), 32'd0);
        end
        chk("abort_no_more_rises", 32'(rise_cyc.size()), 32'(nr));
        $display("abort after %0d rises", nr);

        // New command after abort runs normally from bit 0
        tdo_loop = 1'b0;
        tdo_pat  = 8'h5A;
        run_cmd(1, 7, 8'h96, 8'h81, 1'b1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
